// File: rtl/lcd_frame_streamer_if.sv
// lcd_frame_streamer_if: one-byte valid/ready link from the frame streamer to the I2C byte sender
interface lcd_frame_streamer_if;
   logic       out_valid;
   logic       out_rs;
   logic [7:0] out_data;
   logic       out_ready;
   modport master(output out_valid, out_rs, out_data, input out_ready);
   modport slave(input out_valid, out_rs, out_data, output out_ready);
endinterface

// File: rtl/lcd_frame_streamer.sv
// lcd_frame_streamer: HD44780 power-on init, then re-sends both 16-char rows whenever they change.
// Optional periodic forced refresh when LCD_FORCE_REFRESH_EN is defined.
module lcd_frame_streamer #(
   parameter int unsigned INIT_WAIT_CYCLES = 2_000_000,
   parameter int unsigned GAP_CYCLES       = 2_000,
   parameter int unsigned CLEAR_GAP_CYCLES = 100_000,
   parameter int unsigned REFRESH_CYCLES   = 25_000_000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [127:0]                row1,
   input  logic [127:0]                row2,
   lcd_frame_streamer_if.master        bus,
   output logic                        busy,
   output logic                        frame_done
);
   localparam int unsigned MAX_A = INIT_WAIT_CYCLES > CLEAR_GAP_CYCLES ? INIT_WAIT_CYCLES : CLEAR_GAP_CYCLES;
   localparam int unsigned MAX_W = MAX_A > GAP_CYCLES ? MAX_A : GAP_CYCLES;
   localparam int CW = $clog2(MAX_W + 1);
   localparam logic [7:0][7:0] INIT_SEQ = {8'h33, 8'h32, 8'h28, 8'h0C, 8'h06, 8'h01, 8'h00, 8'h00};

   if (INIT_WAIT_CYCLES == 0 || GAP_CYCLES == 0 || CLEAR_GAP_CYCLES == 0 || REFRESH_CYCLES == 0) begin : g_bad_param
      $error("lcd_frame_streamer: cycle parameters must be nonzero");
   end

   typedef enum logic [2:0] {S_INIT_WAIT, S_INIT_CMD, S_IDLE, S_ADDR1, S_DATA1, S_ADDR2, S_DATA2} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [3:0]       idx_q, idx_d;
   logic             gap_q, gap_d, clr_q, clr_d;
   logic             valid_q, valid_d, rs_q, rs_d;
   logic [7:0]       data_q, data_d;
   logic [31:0][7:0] snap_q, snap_d, shadow_q, shadow_d;
   logic             shv_q, shv_d, done_q, done_d;
   logic             acc, gap_end, free, start, refresh, data_st;
   logic [7:0]       ch, nxt_byte;

   assign acc      = valid_q && bus.out_ready;
   assign gap_end  = gap_q && cnt_q == (clr_q ? CW'(CLEAR_GAP_CYCLES - 1) : CW'(GAP_CYCLES - 1));
   assign free     = !gap_q || gap_end;
   assign start    = state_q == S_IDLE && free && (!shv_q || {row1, row2} != shadow_q || refresh);
   assign data_st  = state_q == S_DATA1 || state_q == S_DATA2;
   // row1 occupies chars 31..16, so the inverted {row, idx} picks the MSB-first character
   assign ch       = snap_q[~{state_q == S_DATA2, idx_q}];
   assign nxt_byte = data_st ? (ch == 8'h00 ? 8'h20 : ch) :
                     state_q == S_INIT_CMD ? INIT_SEQ[~idx_q[2:0]] :
                     state_q == S_ADDR2 ? 8'hC0 : 8'h80;

   assign bus.out_valid = valid_q;
   assign bus.out_rs    = rs_q;
   assign bus.out_data  = data_q;
   assign busy          = !(state_q == S_IDLE && !gap_q);
   assign frame_done    = done_q;

`ifdef LCD_FORCE_REFRESH_EN
   localparam int RW = $clog2(REFRESH_CYCLES + 1);
   logic [RW-1:0] ref_cnt_q;
   logic          ref_flag_q, wrap;
   assign wrap    = ref_cnt_q == RW'(REFRESH_CYCLES - 1);
   assign refresh = ref_flag_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         ref_cnt_q  <= '0;
         ref_flag_q <= 1'b0;
      end else begin
         ref_cnt_q  <= wrap ? '0 : ref_cnt_q + 1'b1;
         ref_flag_q <= wrap || (ref_flag_q && !start);
      end
   end
`else
   assign refresh = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_INIT_WAIT;
         cnt_q    <= '0;
         idx_q    <= '0;
         gap_q    <= 1'b0;
         clr_q    <= 1'b0;
         valid_q  <= 1'b0;
         rs_q     <= 1'b0;
         data_q   <= 8'h00;
         snap_q   <= '0;
         shadow_q <= '0;
         shv_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         gap_q    <= gap_d;
         clr_q    <= clr_d;
         valid_q  <= valid_d;
         rs_q     <= rs_d;
         data_q   <= data_d;
         snap_q   <= snap_d;
         shadow_q <= shadow_d;
         shv_q    <= shv_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      gap_d    = gap_q;
      clr_d    = clr_q;
      valid_d  = valid_q;
      rs_d     = rs_q;
      data_d   = data_q;
      snap_d   = snap_q;
      shadow_d = shadow_q;
      shv_d    = shv_q;
      done_d   = 1'b0;
      if (gap_q) begin
         cnt_d = cnt_q + 1'b1;
         gap_d = !gap_end;
      end
      if (state_q == S_INIT_WAIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CW'(INIT_WAIT_CYCLES - 1)) begin
            state_d = S_INIT_CMD;
            cnt_d   = '0;
         end
      end else if (acc) begin
         valid_d = 1'b0;
         gap_d   = 1'b1;
         cnt_d   = '0;
         clr_d   = !rs_q && data_q == 8'h01;
         idx_d   = (state_q == S_INIT_CMD && idx_q == 4'd5) ? 4'd0 :
                   (state_q == S_ADDR1 || state_q == S_ADDR2) ? idx_q : idx_q + 1'b1;
         state_d = state_q == S_INIT_CMD ? (idx_q == 4'd5 ? S_IDLE : S_INIT_CMD) :
                   state_q == S_ADDR1 ? S_DATA1 :
                   state_q == S_DATA1 ? (idx_q == 4'd15 ? S_ADDR2 : S_DATA1) :
                   state_q == S_ADDR2 ? S_DATA2 : (idx_q == 4'd15 ? S_IDLE : S_DATA2);
         if (state_q == S_DATA2 && idx_q == 4'd15) begin
            shadow_d = snap_q;
            shv_d    = 1'b1;
            done_d   = 1'b1;
         end
      end else if (start) begin
         snap_d  = {row1, row2};
         state_d = S_ADDR1;
         valid_d = 1'b1;
         rs_d    = 1'b0;
         data_d  = 8'h80;
      end else if (state_q != S_IDLE && !valid_q && free) begin
         valid_d = 1'b1;
         rs_d    = data_st;
         data_d  = nxt_byte;
      end
   end
endmodule
